ps2_frame_rx: RTL

System-clock-domain PS/2 receiver that sits directly upstream of the keyboard key decoder. It synchronises and deglitches the raw iPS2CLK/iPS2D pad signals and deserialises each 11-bit device-to-host frame. Each good scan byte is presented with a one-cycle valid strobe, and bad frames are flagged. The decoder then consumes clean bytes instead of clocking logic directly off the PS/2 clock.

---
 rtl/ps2_frame_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver in the system clock domain.
// Synchronises, deglitches and deserialises 11-bit frames into bytes.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2CLK,
    input  logic       iPS2D,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oParityErr,
    output logic       oFrameErr
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [1:0]            clk_sync_q;
    logic [1:0]            dat_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic [FILTER_LEN-1:0] filt_d;
    logic                  fclk_q;
    logic                  fclk_d;
    logic                  fclk_prev_q;

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            bitcnt_q;
    logic [2:0]            bitcnt_d;
    logic [7:0]            shift_q;
    logic [7:0]            shift_d;
    logic                  par_q;
    logic                  par_d;
    logic [TW-1:0]         tocnt_q;
    logic [TW-1:0]         tocnt_d;
    logic [7:0]            code_q;
    logic [7:0]            code_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  perr_q;
    logic                  perr_d;
    logic                  ferr_q;
    logic                  ferr_d;

    logic                  fall;
    logic                  bit_in;
    logic                  timeout;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], iPS2CLK};
            dat_sync_q <= {dat_sync_q[0], iPS2D};
        end
    end

    // Filtered clock only moves once the whole window agrees.
    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
        fclk_d = fclk_q;
        if (filt_q == '0) begin
            fclk_d = 1'b0;
        end else if (filt_q == '1) begin
            fclk_d = 1'b1;
        end
    end

    // Filter window, filtered clock and its one-cycle delayed copy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            filt_q      <= '1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
        end else begin
            filt_q      <= filt_d;
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
        end
    end

    assign fall    = fclk_prev_q & ~fclk_q;
    assign bit_in  = dat_sync_q[1];
    assign timeout = (state_q != IDLE) && (tocnt_q == TO_MAX) && !fall;

    // Frame FSM next state, bit assembly, timeout and result pulses.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;

        if (fall || (state_q == IDLE)) begin
            tocnt_d = '0;
        end else if (tocnt_q != TO_MAX) begin
            tocnt_d = tocnt_q + 1'b1;
        end else begin
            tocnt_d = tocnt_q;
        end

        unique case (state_q)
            IDLE: begin
                if (fall && !bit_in) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d  = {bit_in, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = bit_in;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!bit_in) begin
                        ferr_d = 1'b1;
                    end else if (!(^shift_q ^ par_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    // Frame state, counters and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            tocnt_q  <= '0;
            code_q   <= 8'h00;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tocnt_q  <= tocnt_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign oScanCode  = code_q;
    assign oScanValid = valid_q;
    assign oParityErr = perr_q;
    assign oFrameErr  = ferr_q;

endmodule
